// File: rtl/run_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// Module   : run_ctrl_pkg
// Purpose  : Shared state encoding and defaults for the multicore run controller
// Revision : 1.0
// =============================================================================
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_RUN     = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_e;

    localparam int unsigned DEFAULT_WATCHDOG_CYCLES = 2**20;

endpackage
`default_nettype wire

// File: rtl/run_watchdog.sv
`default_nettype none
// =============================================================================
// Module   : run_watchdog
// Purpose  : RUN-phase cycle counter with terminal-count flag
// Revision : 1.0
// =============================================================================
module run_watchdog
    import run_ctrl_pkg::*;
#(
    parameter int unsigned WATCHDOG_CYCLES = DEFAULT_WATCHDOG_CYCLES,
    parameter int unsigned WD_WIDTH        = 21
) (
    input  logic clk,
    input  logic rstN,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    logic [WD_WIDTH-1:0] count_q;
    logic [WD_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + WD_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flag reflects the pre-increment count so RUN is left before any wrap.
    assign tc_o = (count_q == WD_WIDTH'(WATCHDOG_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/multicore_run_controller.sv
`default_nettype none
// =============================================================================
// Module   : multicore_run_controller
// Purpose  : Launches enabled cores and the run timer, collects completion
// Revision : 1.0
// =============================================================================
module multicore_run_controller
    import run_ctrl_pkg::*;
#(
    parameter int unsigned CORE_COUNT      = 4,
    parameter int unsigned WATCHDOG_CYCLES = DEFAULT_WATCHDOG_CYCLES,
    parameter int unsigned WD_WIDTH        = 21
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  startN,
    input  logic                  clear,
    input  logic [CORE_COUNT-1:0] coreEnable,
    input  logic [CORE_COUNT-1:0] coreDone,
    output logic [CORE_COUNT-1:0] coreStartN,
    output logic                  timerStartN,
    output logic                  timerStop,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [CORE_COUNT-1:0] doneMask
);

    state_e                state_q;
    logic                  start_prev_q;
    logic [CORE_COUNT-1:0] en_mask_q;
    logic [CORE_COUNT-1:0] done_mask_q;
    logic [CORE_COUNT-1:0] done_mask_d;
    logic                  start_edge;
    logic                  launch_req;
    logic                  all_done;
    logic                  wd_tc;

    assign start_edge  = start_prev_q & ~startN;
    assign launch_req  = (state_q == ST_IDLE) & start_edge & (|coreEnable);
    assign done_mask_d = done_mask_q | (coreDone & en_mask_q);
    // Completion looks at this cycle's coreDone so the last finisher is seen at once.
    assign all_done    = (done_mask_d == en_mask_q);

    run_watchdog #(
        .WATCHDOG_CYCLES (WATCHDOG_CYCLES),
        .WD_WIDTH        (WD_WIDTH)
    ) u_watchdog (
        .clk      (clk),
        .rstN     (rstN),
        .clear_i  (launch_req),
        .enable_i (state_q == ST_RUN),
        .tc_o     (wd_tc)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b1;
            en_mask_q    <= '0;
            done_mask_q  <= '0;
        end else begin
            start_prev_q <= startN;
            case (state_q)
                ST_IDLE: begin
                    if (launch_req) begin
                        en_mask_q   <= coreEnable;
                        done_mask_q <= '0;
                        state_q     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    done_mask_q <= done_mask_d;
                    if (all_done) begin
                        state_q <= ST_DONE;
                    end else if (wd_tc) begin
                        state_q <= ST_TIMEOUT;
                    end
                end
                ST_DONE, ST_TIMEOUT: begin
                    if (clear) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign coreStartN  = (state_q == ST_LAUNCH) ? ~en_mask_q : '1;
    assign timerStartN = (state_q != ST_LAUNCH);
    assign timerStop   = (state_q == ST_DONE) | (state_q == ST_TIMEOUT);
    assign busy        = (state_q == ST_LAUNCH) | (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign timeout     = (state_q == ST_TIMEOUT);
    assign doneMask    = done_mask_q;

endmodule
`default_nettype wire

// File: tb/tb_multicore_run_controller.sv
`default_nettype none
// =============================================================================
// Module   : tb_multicore_run_controller
// Purpose  : Self-checking bench: vector table, corner sequences, random vs model
// Revision : 1.0
// =============================================================================
module tb_multicore_run_controller;

    localparam int WC = 16;

    logic       clk = 1'b0;
    logic       rstN;
    logic       startN;
    logic       clear;
    logic [3:0] coreEnable;
    logic [3:0] coreDone;
    logic [3:0] coreStartN;
    logic       timerStartN;
    logic       timerStop;
    logic       busy;
    logic       done;
    logic       timeout;
    logic [3:0] doneMask;

    int checks   = 0;
    int failures = 0;

    multicore_run_controller #(
        .CORE_COUNT      (4),
        .WATCHDOG_CYCLES (WC),
        .WD_WIDTH        (5)
    ) dut (
        .clk         (clk),
        .rstN        (rstN),
        .startN      (startN),
        .clear       (clear),
        .coreEnable  (coreEnable),
        .coreDone    (coreDone),
        .coreStartN  (coreStartN),
        .timerStartN (timerStartN),
        .timerStop   (timerStop),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .doneMask    (doneMask)
    );

    always #5 clk = ~clk;

    // Reference model: a run is "active" from its start edge; m_age counts edges since it.
    bit         m_prev;
    bit         m_active;
    bit         m_fin_ok;
    bit         m_fin_to;
    int         m_age;
    logic [3:0] m_en;
    logic [3:0] m_dm;

    function automatic void model_reset();
        m_prev   = 1'b1;
        m_active = 1'b0;
        m_fin_ok = 1'b0;
        m_fin_to = 1'b0;
        m_age    = 0;
        m_en     = '0;
        m_dm     = '0;
    endfunction

    function automatic void model_step();
        bit se;
        se = m_prev && !startN;
        if (m_active) begin
            m_age++;
            if (m_age >= 2) begin
                m_dm = m_dm | (coreDone & m_en);
                if (m_dm == m_en) begin
                    m_active = 1'b0;
                    m_fin_ok = 1'b1;
                end else if (m_age == WC + 1) begin
                    m_active = 1'b0;
                    m_fin_to = 1'b1;
                end
            end
        end else if (m_fin_ok || m_fin_to) begin
            if (clear) begin
                m_fin_ok = 1'b0;
                m_fin_to = 1'b0;
            end
        end else if (se && coreEnable != 4'b0000) begin
            m_active = 1'b1;
            m_age    = 0;
            m_en     = coreEnable;
            m_dm     = '0;
        end
        m_prev = startN;
    endfunction

    function automatic logic [12:0] model_outputs();
        logic       launch;
        launch = m_active && (m_age == 0);
        return {launch ? ~m_en : 4'hF, !launch, m_fin_ok | m_fin_to,
                m_active, m_fin_ok, m_fin_to, m_dm};
    endfunction

    function automatic logic [12:0] dut_outputs();
        return {coreStartN, timerStartN, timerStop, busy, done, timeout, doneMask};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rstN) model_reset();
        else model_step();
        #1;
        chk("cycle_vs_model", {3'b0, dut_outputs()}, {3'b0, model_outputs()});
    endtask

    typedef struct {
        logic       sn;
        logic       clr;
        logic [3:0] en;
        logic [3:0] cd;
        logic [3:0] csn;
        logic       tsn;
        logic       stop;
        logic       bsy;
        logic       dn;
        logic       to;
        logic [3:0] dm;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        // Normal run with enable 1011; core 2 raises done while disabled.
        tbl[0]  = '{1'b0, 1'b0, 4'b1011, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000};
        tbl[1]  = '{1'b0, 1'b0, 4'b1011, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000};
        tbl[2]  = '{1'b0, 1'b0, 4'b1011, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000};
        tbl[3]  = '{1'b0, 1'b0, 4'b1011, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000};
        tbl[4]  = '{1'b0, 1'b0, 4'b1011, 4'b0001, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001};
        tbl[5]  = '{1'b0, 1'b0, 4'b1011, 4'b0001, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001};
        tbl[6]  = '{1'b0, 1'b0, 4'b1011, 4'b0111, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0011};
        tbl[7]  = '{1'b0, 1'b0, 4'b1011, 4'b0010, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0011};
        tbl[8]  = '{1'b0, 1'b0, 4'b1011, 4'b1011, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1011};
        tbl[9]  = '{1'b0, 1'b0, 4'b1011, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1011};
        tbl[10] = '{1'b0, 1'b1, 4'b1011, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011};
        tbl[11] = '{1'b1, 1'b0, 4'b1011, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011};
        tbl[12] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011};
        tbl[13] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011};

        rstN = 1'b0; startN = 1'b1; clear = 1'b0; coreEnable = '0; coreDone = '0;
        model_reset();
        tick(); tick();
        chk("reset_state", {3'b0, dut_outputs()}, {3'b0, 13'b1111_1_0_0_0_0_0000});
        rstN = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            startN = tbl[i].sn; clear = tbl[i].clr;
            coreEnable = tbl[i].en; coreDone = tbl[i].cd;
            tick();
            chk($sformatf("table_row%0d", i), {3'b0, dut_outputs()},
                {3'b0, tbl[i].csn, tbl[i].tsn, tbl[i].stop, tbl[i].bsy,
                 tbl[i].dn, tbl[i].to, tbl[i].dm});
        end

        // Timeout: only core 0 of 0011 ever finishes.
        coreEnable = 4'b0011; coreDone = '0; startN = 1'b0;
        tick();
        chk("to_launch_dm_fresh", {12'b0, doneMask}, 16'h0);
        chk("to_launch_csn", {12'b0, coreStartN}, 16'h000C);
        tick();
        coreDone = 4'b0001;
        n = 0;
        while (!timeout && n < 40) begin
            tick();
            n++;
        end
        chk("to_latency", n[15:0], 16'd16);
        chk("to_dm", {12'b0, doneMask}, 16'h0001);
        chk("to_stop_done", {14'b0, timerStop, done}, 16'b10);

        clear = 1'b1; startN = 1'b1; coreDone = '0;
        tick();
        clear = 1'b0;
        tick();

        // Tie: last core completes on the same edge the watchdog expires.
        startN = 1'b0;
        tick();
        tick();
        coreDone = 4'b0001;
        for (int i = 0; i < 15; i++) tick();
        chk("tie_still_busy", {15'b0, busy}, 16'h1);
        coreDone = 4'b0011;
        tick();
        chk("tie_done_wins", {13'b0, done, timeout, timerStop}, 16'b101);

        // startN held low across clear must not restart.
        coreDone = '0; clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (3) tick();
        chk("held_low_no_restart", {15'b0, busy}, 16'h0);
        startN = 1'b1;
        tick();
        startN = 1'b0;
        tick();
        chk("rearm_launch", {11'b0, busy, coreStartN}, {11'b0, 1'b1, 4'b1100});
        repeat (4) tick();

        // Asynchronous reset in the middle of RUN.
        #3 rstN = 1'b0;
        #1;
        model_reset();
        chk("async_reset_mid_run", {3'b0, dut_outputs()}, {3'b0, 13'b1111_1_0_0_0_0_0000});
        startN = 1'b1;
        tick();
        rstN = 1'b1;
        tick();

        // Re-run after reset completes normally.
        coreEnable = 4'b0101; startN = 1'b0;
        tick();
        chk("rerun_launch_csn", {12'b0, coreStartN}, 16'h000A);
        tick();
        coreDone = 4'b0101;
        tick();
        chk("rerun_done", {11'b0, done, doneMask}, {11'b0, 1'b1, 4'b0101});
        clear = 1'b1; coreDone = '0;
        tick();
        clear = 1'b0;

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(3) == 0) startN = ~startN;
            clear      = ($urandom_range(5) == 0);
            coreEnable = 4'($urandom);
            coreDone   = 4'($urandom & $urandom & $urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
